// File: rtl/lm_sm_sequencer.sv
// Load-Multiple / Store-Multiple sequencer: walks a register mask lowest-bit-first,
// issuing one register index and memory word address per transfer while freezing the PC.
module lm_sm_sequencer #(
   parameter int DATA_W    = 16,
   parameter int ADDR_STEP = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              isStore,
   input  logic [7:0]        mask,
   input  logic [DATA_W-1:0] baseAddr,
   input  logic              stall,
   output logic              busy,
   output logic              freezePC,
   output logic [2:0]        regAdd,
   output logic [DATA_W-1:0] memAdd,
   output logic              regWrite,
   output logic              memRead,
   output logic              memWrite,
   output logic              done,
   output logic [3:0]        xferCount
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [6:0]        r_rem_mask;
   logic [6:0]        w_rem_cleared;
   logic [DATA_W-1:0] r_addr;
   logic              r_is_store;
   logic [3:0]        r_xfer_count;
   logic [2:0]        w_low_idx;
   logic              w_xfer;
   logic              w_unused_r7;

   // R7 is written through its own path, so its mask bit never enters the walk.
   assign w_unused_r7 = mask[7];

   always_comb begin
      w_low_idx = 3'd0;
      for (int i = 6; i >= 0; i--) begin
         if (r_rem_mask[i]) w_low_idx = 3'(i);
      end
   end

   // x & (x-1) drops exactly the lowest set bit, i.e. the one being transferred.
   assign w_rem_cleared = r_rem_mask & (r_rem_mask - 7'd1);
   assign w_xfer        = (r_state == S_RUN) && !stall;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_next = (mask[6:0] != 7'd0) ? S_RUN : S_DONE;
         S_RUN:   if (w_xfer && (w_rem_cleared == 7'd0)) w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_rem_mask   <= 7'd0;
         r_addr       <= '0;
         r_is_store   <= 1'b0;
         r_xfer_count <= 4'd0;
      end else begin
         r_state <= w_state_next;
         if ((r_state == S_IDLE) && start) begin
            r_rem_mask   <= mask[6:0];
            r_addr       <= baseAddr;
            r_is_store   <= isStore;
            r_xfer_count <= 4'd0;
         end else if (w_xfer) begin
            r_rem_mask   <= w_rem_cleared;
            r_addr       <= r_addr + DATA_W'(ADDR_STEP);
            r_xfer_count <= r_xfer_count + 4'd1;
         end
      end
   end

   // NOTE: every output is given a default before the case so no path infers a latch.
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      regAdd   = 3'd0;
      memAdd   = '0;
      regWrite = 1'b0;
      memRead  = 1'b0;
      memWrite = 1'b0;
      case (r_state)
         S_RUN: begin
            busy     = 1'b1;
            regAdd   = w_low_idx;
            memAdd   = r_addr;
            regWrite = ~r_is_store & ~stall;
            memRead  = ~r_is_store & ~stall;
            memWrite =  r_is_store & ~stall;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign freezePC  = busy;
   assign xferCount = r_xfer_count;

endmodule
